// File: rtl/dtt_xbar_ingress_port.sv
// dtt_xbar_ingress_port
// Transmit-side adapter for one crossbar input port. Buffers a ready/valid
// word stream (payload + destination index) in a local FIFO and issues words
// to the crossbar's valid-only input when the destination has credit.
// Egress returns credits as crossbar output queues drain.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   s_valid/s_ready     upstream handshake; s_data payload, s_dest binary dest
//   xb_valid            one-cycle issue strobe; xb_data/xb_dest issued word
//   cr_return           per-destination credit return, one credit per set bit
//   dest_err            sticky: word with out-of-range dest accepted and dropped
//   cr_ovf              sticky: credit returned to a counter already full
//
// Optional feature (macro DTT_INGRESS_STATS_EN):
//   stat_issued, stat_dropped, stat_stall free-running wrap-around counters.
module dtt_xbar_ingress_port #(
    parameter int N_OUT      = 4,
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 8,
    parameter int CREDITS    = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic [N_OUT-1:0]      s_dest,
    output logic                  xb_valid,
    output logic [DATA_WIDTH-1:0] xb_data,
    output logic [N_OUT-1:0]      xb_dest,
    input  logic [N_OUT-1:0]      cr_return,
    output logic                  dest_err,
    output logic                  cr_ovf
`ifdef DTT_INGRESS_STATS_EN
    ,
    output logic [31:0]           stat_issued,
    output logic [15:0]           stat_dropped,
    output logic [31:0]           stat_stall
`endif
);

    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int CW  = AW + 1;
    localparam int CRW = $clog2(CREDITS + 1);
    localparam int IW  = (N_OUT > 1) ? $clog2(N_OUT) : 1;

    localparam logic [CW-1:0]  DEPTH_V   = CW'(FIFO_DEPTH);
    localparam logic [CRW-1:0] CREDITS_V = CRW'(CREDITS);
    localparam logic [N_OUT:0] N_OUT_V   = (N_OUT + 1)'(N_OUT);

    logic [DATA_WIDTH-1:0] mem_data [FIFO_DEPTH];
    logic [N_OUT-1:0]      mem_dest [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [CW-1:0]         count;

    logic [CRW-1:0]        credit [N_OUT];

    logic                  accept;
    logic                  dest_ok;
    logic                  push;
    logic                  drop;
    logic                  issue;
    logic [IW-1:0]         head_idx;
    logic                  head_has_credit;
    logic [N_OUT-1:0]      issue_vec;
    logic [N_OUT-1:0]      at_max;
    logic                  ovf_hit;

    assign s_ready = (count < DEPTH_V);
    assign accept  = s_valid && s_ready;
    assign dest_ok = ({1'b0, s_dest} < N_OUT_V);
    assign push    = accept && dest_ok;
    assign drop    = accept && !dest_ok;

    // Only in-range destinations are ever written, so the low IW bits of a
    // stored dest are a valid counter index.
    assign head_idx        = mem_dest[rd_ptr][IW-1:0];
    assign head_has_credit = (credit[head_idx] != '0);
    assign issue           = (count != '0) && head_has_credit;

    always_comb begin
        issue_vec = '0;
        at_max    = '0;
        if (issue) begin
            issue_vec[head_idx] = 1'b1;
        end
        for (int unsigned j = 0; j < N_OUT; j++) begin
            at_max[j] = (credit[j] == CREDITS_V);
        end
    end

    // A return only overflows if no issue on the same counter absorbs it.
    assign ovf_hit = |(cr_return & ~issue_vec & at_max);

    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wr_ptr] <= s_data;
            mem_dest[wr_ptr] <= s_dest;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (issue) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, issue})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned j = 0; j < N_OUT; j++) begin
                credit[j] <= CREDITS_V;
            end
        end else begin
            for (int unsigned j = 0; j < N_OUT; j++) begin
                if (issue_vec[j] && !cr_return[j]) begin
                    credit[j] <= credit[j] - CRW'(1);
                end else if (!issue_vec[j] && cr_return[j] && !at_max[j]) begin
                    credit[j] <= credit[j] + CRW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xb_valid <= 1'b0;
            xb_data  <= '0;
            xb_dest  <= '0;
            dest_err <= 1'b0;
            cr_ovf   <= 1'b0;
        end else begin
            xb_valid <= issue;
            if (issue) begin
                xb_data <= mem_data[rd_ptr];
                xb_dest <= mem_dest[rd_ptr];
            end
            if (drop) begin
                dest_err <= 1'b1;
            end
            if (ovf_hit) begin
                cr_ovf <= 1'b1;
            end
        end
    end

`ifdef DTT_INGRESS_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_issued  <= '0;
            stat_dropped <= '0;
            stat_stall   <= '0;
        end else begin
            if (xb_valid) begin
                stat_issued <= stat_issued + 32'd1;
            end
            if (drop) begin
                stat_dropped <= stat_dropped + 16'd1;
            end
            if ((count != '0) && !head_has_credit) begin
                stat_stall <= stat_stall + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dtt_xbar_ingress_port.sv
module tb_dtt_xbar_ingress_port;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        s_valid;
    logic        s_ready;
    logic [31:0] s_data;
    logic [3:0]  s_dest;
    logic        xb_valid;
    logic [31:0] xb_data;
    logic [3:0]  xb_dest;
    logic [3:0]  cr_return;
    logic        dest_err;
    logic        cr_ovf;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] got_data [$];
    logic [3:0]  got_dest [$];

    dtt_xbar_ingress_port #(
        .N_OUT      (4),
        .DATA_WIDTH (32),
        .FIFO_DEPTH (8),
        .CREDITS    (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .s_dest    (s_dest),
        .xb_valid  (xb_valid),
        .xb_data   (xb_data),
        .xb_dest   (xb_dest),
        .cr_return (cr_return),
        .dest_err  (dest_err),
        .cr_ovf    (cr_ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock, sample 1 time unit after the edge, log any issue.
    task automatic step();
        @(posedge clk);
        #1;
        if (xb_valid === 1'b1) begin
            got_data.push_back(xb_data);
            got_dest.push_back(xb_dest);
        end
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic clear_log();
        got_data.delete();
        got_dest.delete();
    endtask

    task automatic push_word(input logic [31:0] d, input logic [3:0] dst);
        s_valid = 1'b1;
        s_data  = d;
        s_dest  = dst;
        step();
        s_valid = 1'b0;
    endtask

    task automatic return_credits(input logic [3:0] mask, input int n);
        for (int i = 0; i < n; i++) begin
            cr_return = mask;
            step();
        end
        cr_return = 4'b0000;
    endtask

    initial begin
        rst_n     = 1'b0;
        s_valid   = 1'b0;
        s_data    = '0;
        s_dest    = '0;
        cr_return = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;

        // Reset state
        check("rst_s_ready", s_ready, 1);
        check("rst_xb_valid", xb_valid, 0);
        check("rst_xb_data", xb_data, 0);
        check("rst_xb_dest", xb_dest, 0);
        check("rst_dest_err", dest_err, 0);
        check("rst_cr_ovf", cr_ovf, 0);

        // Single word latency: accept edge E, strobe after E+1 only
        @(posedge clk); #1;
        clear_log();
        push_word(32'hA5A5_0001, 4'd2);
        check("t1_lat_e", xb_valid, 0);
        step();
        check("t1_valid", xb_valid, 1);
        check("t1_data", xb_data, 32'hA5A5_0001);
        check("t1_dest", xb_dest, 2);
        check("t1_credit2", dut.credit[2], 3);
        step();
        check("t1_one_shot", xb_valid, 0);
        check("t1_data_hold", xb_data, 32'hA5A5_0001);
        return_credits(4'b0100, 1);
        check("t1_credit2_back", dut.credit[2], 4);
        check("t1_no_ovf", cr_ovf, 0);

        // Same-cycle issue and return on dest 3: net unchanged, no overflow
        push_word(32'h0000_0033, 4'd3);
        cr_return = 4'b1000;
        step();
        cr_return = 4'b0000;
        check("t5_issue", xb_valid, 1);
        check("t5_credit3", dut.credit[3], 4);
        check("t5_no_ovf", cr_ovf, 0);

        // Return to a full counter: saturate and flag
        return_credits(4'b0001, 1);
        check("t5_credit0_sat", dut.credit[0], 4);
        check("t5_ovf", cr_ovf, 1);
        steps(2);
        check("t5_ovf_sticky", cr_ovf, 1);

        // 6 words to dest 1 with 4 credits: 4 issue back to back, then stall
        clear_log();
        for (int i = 0; i < 6; i++) begin
            check("t2_s_ready", s_ready, 1);
            push_word(32'h0000_0100 + i, 4'd1);
        end
        steps(6);
        check("t2_issue_cnt", got_data.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < got_data.size()) check("t2_order", got_data[i], 32'h0000_0100 + i);
        end
        check("t2_credit1", dut.credit[1], 0);
        check("t2_s_ready_stall", s_ready, 1);
        clear_log();
        return_credits(4'b0010, 1);
        check("t2_ret_lat", xb_valid, 0);
        step();
        check("t2_ret_issue", xb_valid, 1);
        check("t2_ret_data", xb_data, 32'h0000_0104);
        steps(3);
        check("t2_ret_cnt", got_data.size(), 1);
        return_credits(4'b0010, 1);
        steps(3);
        check("t2_drain_cnt", got_data.size(), 2);
        return_credits(4'b0010, 4);
        check("t2_credit1_full", dut.credit[1], 4);

        // Exhaust dest 0, then fill FIFO behind the blocked head
        clear_log();
        for (int i = 0; i < 4; i++) push_word(32'h0000_0200 + i, 4'd0);
        steps(4);
        check("t3_exhaust_cnt", got_data.size(), 4);
        check("t3_credit0", dut.credit[0], 0);
        clear_log();
        for (int i = 0; i < 8; i++) begin
            check("t3_fill_ready", s_ready, 1);
            push_word(32'h0000_0300 + i, 4'd0);
        end
        check("t3_full", s_ready, 0);
        push_word(32'h0000_DEAD, 4'd0);
        check("t3_full_hold", s_ready, 0);
        check("t3_no_issue", got_data.size(), 0);
        return_credits(4'b0001, 8);
        steps(3);
        check("t3_drain_cnt", got_data.size(), 8);
        for (int i = 0; i < 8; i++) begin
            if (i < got_data.size()) begin
                check("t3_order", got_data[i], 32'h0000_0300 + i);
                check("t3_dest", got_dest[i], 0);
            end
        end
        check("t3_ready_back", s_ready, 1);
        check("t3_credit0_end", dut.credit[0], 0);

        // Out-of-range destination: handshake completes, word dropped
        clear_log();
        check("t4_err_pre", dest_err, 0);
        s_valid = 1'b1;
        s_data  = 32'h0000_0BAD;
        s_dest  = 4'd5;
        check("t4_ready", s_ready, 1);
        step();
        s_valid = 1'b0;
        check("t4_err", dest_err, 1);
        steps(4);
        check("t4_no_issue", got_data.size(), 0);
        check("t4_err_sticky", dest_err, 1);

        // Reset mid-stream with 5 words queued and a strobe in flight
        clear_log();
        for (int i = 0; i < 6; i++) push_word(32'h0000_0400 + i, 4'd0);
        return_credits(4'b0001, 1);
        step();
        check("t6_inflight", xb_valid, 1);
        check("t6_count", dut.count, 5);
        rst_n = 1'b0;
        #1;
        check("t6_rst_valid", xb_valid, 0);
        check("t6_rst_count", dut.count, 0);
        check("t6_rst_cr0", dut.credit[0], 4);
        check("t6_rst_cr1", dut.credit[1], 4);
        check("t6_rst_cr2", dut.credit[2], 4);
        check("t6_rst_cr3", dut.credit[3], 4);
        check("t6_rst_err", dest_err, 0);
        check("t6_rst_ovf", cr_ovf, 0);
        @(negedge clk);
        rst_n = 1'b1;
        clear_log();
        steps(8);
        check("t6_no_stale", got_data.size(), 0);
        push_word(32'h0000_0077, 4'd3);
        steps(3);
        check("t6_post_cnt", got_data.size(), 1);
        if (got_data.size() > 0) check("t6_post_data", got_data[0], 32'h0000_0077);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/dtt_xbar_ingress_port.md
Name: dtt_xbar_ingress_port

Overview:
Transmit-side adapter feeding one input port of the crossbar switch. Accepts a ready/valid word stream tagged with a destination index and buffers it in a local FIFO. Issues words to the crossbar's valid-only port (no backpressure) only when the per-destination credit counter is non-zero. Egress logic returns credits as the crossbar output queues drain, so the crossbar queues can never overflow.

Parameters:
N_OUT, 4, number of crossbar output ports / credit counters
DATA_WIDTH, 32, payload width
FIFO_DEPTH, 8, ingress FIFO entries; power of two, >= 2
CREDITS, 4, initial and maximum credits per destination; >= 1

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
s_valid  input  1  upstream word valid
s_ready  output  1  upstream ready; word accepted when s_valid && s_ready at clk edge
s_data  input  DATA_WIDTH  upstream payload
s_dest  input  N_OUT  binary destination index, zero-extended
xb_valid  output  1  one-cycle issue strobe to crossbar in_valid
xb_data  output  DATA_WIDTH  issued payload
xb_dest  output  N_OUT  issued destination index (binary, crossbar encoding)
cr_return  input  N_OUT  per-destination credit return; bit j high = one credit back for dest j; any number of bits per cycle
dest_err  output  1  sticky: a word with s_dest >= N_OUT was accepted and dropped
cr_ovf  output  1  sticky: credit returned to a counter already at CREDITS

Behaviour:
- Reset (async assert, sync deassert by integrator): FIFO empty, all credit counters = CREDITS, xb_valid=0, xb_data=0, xb_dest=0, dest_err=0, cr_ovf=0, s_ready=1 in the first cycle after reset. Reset mid-operation discards FIFO contents and in-flight strobes immediately.
- s_ready = (fifo_count < FIFO_DEPTH), from registered count. When full, no push, even if a pop occurs the same cycle.
- Push: on accept, if s_dest < N_OUT, write {s_data, s_dest} to the FIFO tail. Otherwise drop the word, set dest_err, and leave the FIFO unchanged. The upstream still sees the handshake complete.
- Issue: each cycle, if FIFO is non-empty and credit[head.dest] > 0:
  - pop head
  - register xb_valid=1, xb_data, xb_dest for exactly one cycle
  - decrement credit[head.dest]
  Otherwise xb_valid=0 next cycle; xb_data and xb_dest hold their last value.
- At most one issue per cycle. Strict FIFO order: a blocked head stalls all younger words (head-of-line blocking is intended).
- Latency: a word accepted at edge E into an empty FIFO with credit available gives xb_valid high in the cycle following edge E+1 (one FIFO cycle, no bypass). Back-to-back issue sustains 1 word/cycle.
- Credit counters: width $clog2(CREDITS+1), unsigned.
  - Per destination j, per cycle: next = cur - issue_j + cr_return[j].
  - Issue and return on the same j in the same cycle: net unchanged.
  - Return when cur == CREDITS with no same-cycle issue: saturate at CREDITS and set cr_ovf.
  - A counter never underflows, because issue requires cur > 0.
- FIFO pointers: log2(FIFO_DEPTH) bits with natural wrap, plus a separate count register of log2(FIFO_DEPTH)+1 bits. Simultaneous push and pop when not full: count unchanged.
- Sticky flags clear only on reset.

Optional Feature:
Macro DTT_INGRESS_STATS_EN.
- Defined: adds outputs stat_issued [31:0] (count of xb_valid strobes), stat_dropped [15:0] (count of dest_err drops) and stat_stall [31:0] (cycles with FIFO non-empty but head blocked by zero credit). All counters reset to 0, wrap modulo 2^width, and do not change any other behaviour.
- Not defined: these ports and counters are absent.

Test Plan:
- Reset, then push 1 word (data 0xA5A5_0001, dest 2) → xb_valid high exactly one cycle, 2 clocks after the accept edge, xb_dest=2; credit[2] goes 4→3.
- Push 6 words to dest 1 with no cr_return → first 4 issue on consecutive cycles, then stall; s_ready stays 1; one cr_return[1] pulse → exactly one more issue on the next cycle.
- Block dest 0 (credits exhausted), push 8 more words with dest 0 → FIFO fills, s_ready=0 after the 8th accept; return 8 credits one per cycle → all 8 issue in order and s_ready returns to 1.
- Push a word with s_dest=5 (N_OUT=4) → handshake completes, no xb_valid, dest_err=1 and stays 1 until reset.
- Same-cycle issue to dest 3 and cr_return[3]=1 → credit[3] unchanged. Separately, cr_return[0] with credit[0]=4 → stays 4, cr_ovf=1.
- Assert rst_n low mid-stream with 5 words queued → FIFO empty, xb_valid=0, credits=4 immediately. After release, no stale word issues.
